// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, reset constants and datapath width.
package mips_pkg;

  localparam int ADDR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ADDR_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// Bus between the fetch/IF-ID stage and its surroundings (controller, hazard unit, I-mem).
interface fetch_ifid_stage_if;
  import mips_pkg::*;

  logic              In_Stall;
  logic              In_PCSrc;
  logic              In_JumpPC;
  logic [ADDR_W-1:0] In_BranchOffset;
  logic [ADDR_W-1:0] In_IMemData;
  logic [ADDR_W-1:0] Out_IMemAddr;
  logic [ADDR_W-1:0] Out_IFID_Instr;
  logic [ADDR_W-1:0] Out_IFID_PCPlus4;
  logic              Out_IFID_Valid;
  logic [5:0]        Out_Opcode;
  logic              Out_Flush;
  logic [15:0]       Out_BubbleCount;

  // The fetch stage itself
  modport master (
    input  In_Stall, In_PCSrc, In_JumpPC, In_BranchOffset, In_IMemData,
    output Out_IMemAddr, Out_IFID_Instr, Out_IFID_PCPlus4, Out_IFID_Valid,
           Out_Opcode, Out_Flush, Out_BubbleCount
  );

  // Controller / memory side
  modport slave (
    output In_Stall, In_PCSrc, In_JumpPC, In_BranchOffset, In_IMemData,
    input  Out_IMemAddr, Out_IFID_Instr, Out_IFID_PCPlus4, Out_IFID_Valid,
           Out_Opcode, Out_Flush, Out_BubbleCount
  );

endinterface

// File: rtl/fetch_ifid_stage_next_pc_sel.sv
// Next-PC priority mux: hold on stall, then jump, then branch, else sequential.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [ADDR_W-1:0] ifid_pcplus4,
  input  logic [25:0]       instr_index,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              stall,
  input  logic              redir,
  input  logic              jump,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;

  // Redirect targets are relative to the instruction sitting in ID; branch arithmetic wraps
  always_comb begin
    jump_target   = {ifid_pcplus4[31:28], instr_index, 2'b00};
    branch_target = ifid_pcplus4 + {branch_offset[29:0], 2'b00};
  end

  // A redirect only exists when PCSrc or JumpPC is set, so a non-jump redirect is a branch
  always_comb begin
    next_pc = pc_plus4;
    if (stall) begin
      next_pc = pc;
    end else if (redir && jump) begin
      next_pc = jump_target;
    end else if (redir) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage with PC register and IF/ID pipeline register.
module fetch_ifid_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC_P = RESET_PC,
  parameter logic [ADDR_W-1:0] NOP_WORD_P = NOP_WORD
) (
  input logic               clk,
  input logic               rst,
  fetch_ifid_stage_if.master bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0] ifid_pcplus4;
  logic              ifid_valid;
  logic [15:0]       bubble_count;
  logic              redir;

  // Bubbles never redirect, and a stalled redirect waits for the stall to lift
  always_comb begin
    pc_plus4 = pc + 32'd4;
    redir    = ifid_valid & ~bus.In_Stall & (bus.In_JumpPC | bus.In_PCSrc);
  end

  next_pc_sel u_next_pc_sel (
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ifid_pcplus4  (ifid_pcplus4),
    .instr_index   (ifid_instr[25:0]),
    .branch_offset (bus.In_BranchOffset),
    .stall         (bus.In_Stall),
    .redir         (redir),
    .jump          (bus.In_JumpPC),
    .next_pc       (next_pc)
  );

  // PC, IF/ID register and bubble counter; a redirect squashes the word fetched this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC_P;
      ifid_instr   <= NOP_WORD_P;
      ifid_pcplus4 <= 32'h0000_0000;
      ifid_valid   <= 1'b0;
      bubble_count <= 16'h0000;
    end else begin
      pc <= next_pc;
      if (!bus.In_Stall) begin
        ifid_pcplus4 <= pc_plus4;
        if (redir) begin
          ifid_instr <= NOP_WORD_P;
          ifid_valid <= 1'b0;
        end else begin
          ifid_instr <= bus.In_IMemData;
          ifid_valid <= 1'b1;
        end
      end
      if (redir && (bubble_count != 16'hFFFF)) begin
        bubble_count <= bubble_count + 16'd1;
      end
    end
  end

  assign bus.Out_IMemAddr     = pc;
  assign bus.Out_IFID_Instr   = ifid_instr;
  assign bus.Out_IFID_PCPlus4 = ifid_pcplus4;
  assign bus.Out_IFID_Valid   = ifid_valid;
  assign bus.Out_Opcode       = ifid_instr[31:26];
  assign bus.Out_Flush        = redir;
  assign bus.Out_BubbleCount  = bubble_count;

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the MIPS core.
- Upstream of the controller: it holds the PC, drives the instruction-memory address and latches the fetched word. It presents the opcode field to the controller.
- Consumes the controller's PCSrc/JumpPC decisions, made in ID, to redirect the PC. It squashes the wrongly fetched instruction.
- Supports a hazard stall and produces a single-cycle bubble on every taken redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
In_Stall  input  1  hazard stall from ID; freeze PC and IF/ID
In_PCSrc  input  1  branch taken (controller PCSrc, already qualified by Is0)
In_JumpPC  input  1  unconditional jump (controller JumpPC)
In_BranchOffset  input  32  sign-extended 16-bit immediate of the ID instruction
In_IMemData  input  32  instruction word read combinationally at Out_IMemAddr
Out_IMemAddr  output  32  current PC, sent to instruction memory
Out_IFID_Instr  output  32  registered instruction in ID
Out_IFID_PCPlus4  output  32  registered PC+4 of the ID instruction
Out_IFID_Valid  output  1  1 = ID holds a real instruction, 0 = bubble
Out_Opcode  output  6  Out_IFID_Instr[31:26], sent to the controller In_Opcode
Out_Flush  output  1  combinational; high in the cycle a redirect is accepted
Out_BubbleCount  output  16  saturating count of flush bubbles since reset

Behaviour:
- Reset (rst=1 at edge):
  - PC <= RESET_PC; IF/ID instruction <= NOP_WORD; PCPlus4 <= 0; Valid <= 0; BubbleCount <= 0.
  - Reset mid-stall or mid-redirect overrides everything.
- Redirect acceptance (combinational): redir = Out_IFID_Valid & ~In_Stall & (In_JumpPC | In_PCSrc).
- Targets:
  - Jump target = {IFID_PCPlus4[31:28], IFID_Instr[25:0], 2'b00}.
  - Branch target = IFID_PCPlus4 + (In_BranchOffset << 2). Use 32-bit arithmetic; wrap-around modulo 2^32 with no overflow flag.
- Next-PC priority (highest first):
  1. rst
  2. In_Stall: PC is held
  3. redir with In_JumpPC: jump target, regardless of In_PCSrc
  4. redir with In_PCSrc: branch target
  5. otherwise PC+4 (wraps 32'hFFFF_FFFC -> 0)
- IF/ID update:
  - In_Stall=1: hold all IF/ID fields. A redirect requested during a stall is ignored; the held instruction re-asserts it on the first unstalled cycle.
  - redir=1: Instr <= NOP_WORD, Valid <= 0, PCPlus4 <= PC+4 of the squashed fetch. Exactly one bubble results.
  - Otherwise: Instr <= In_IMemData, PCPlus4 <= PC+4, Valid <= 1.
- Bubble state: Out_IFID_Valid=0 means the controller sees opcode 0. PCSrc/JumpPC requests while Valid=0 are ignored, so no redirect ever comes from a bubble.
- Out_Flush = redir.
- Out_BubbleCount increments on each redir and saturates at 16'hFFFF.
- Latency: fetch-to-ID is 1 cycle. Redirect penalty is 1 cycle: the target instruction reaches ID two edges after the branch sits in ID.
- After reset: the first edge with rst=0 and no stall loads mem[RESET_PC] with Valid=1.
- PC bits [1:0] are always 0; no misalignment check.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_J=6'h02, OP_LW=6'h23, OP_SW=6'h2B)
  - NOP_WORD
  - RESET_PC default
  - ADDR_W=32
- One sub-module, next_pc_sel: pure combinational priority mux for PC+4, branch target and jump target.
- Registers stay in fetch_ifid_stage.

Test Plan:
- Reset/sequential:
  - Stimulus: rst 2 cycles, mem[0]=32'h8C08_0004, mem[4]=32'h0109_5020.
  - Response: Out_IMemAddr 0 -> 4 -> 8. ID shows Instr 8C08_0004, Valid=1, PCPlus4=4, then 0109_5020. Out_Opcode=6'h23.
- Taken branch:
  - Stimulus: BEQ in ID with PCPlus4=0x14, In_BranchOffset=3, In_PCSrc=1.
  - Response: Out_Flush=1; next PC=0x20; next ID Valid=0 with Instr 0; BubbleCount=1.
- Jump priority:
  - Stimulus: IFID_Instr=32'h0800_0040, PCPlus4=0x1000_0008, In_JumpPC=1 and In_PCSrc=1 together.
  - Response: next PC=0x1000_0100.
- Stall:
  - Stimulus: In_Stall=1 for 3 cycles with In_PCSrc=1.
  - Response: PC and IF/ID constant and Out_Flush=0 throughout. On release, redirect is taken once.
- Bubble immunity and reset mid-redirect:
  - Stimulus: In_PCSrc=1 while Valid=0.
  - Response: no redirect; PC+4 proceeds.
  - Stimulus: rst asserted in the same cycle as redir.
  - Response: PC=RESET_PC, Valid=0, BubbleCount=0.
- Wrap and branch overflow:
  - Stimulus: PC=32'hFFFF_FFFC.
  - Response: next PC=0.
  - Stimulus: branch offset 32'hFFFF_FFFF with PCPlus4=0.
  - Response: target 32'hFFFF_FFFC.
